// File: rtl/hilo_sequencer.sv
// rtl/hilo_sequencer.sv - mult/div sequencer: zero-divisor check, start pulse, watchdog wait, HI/LO write
module hilo_sequencer #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_sel,
  input  logic [31:0] rt_val,
  output logic        op_ready,
  output logic        mult_start,
  input  logic        mult_done,
  output logic        div_start,
  input  logic        div_done,
  output logic        hilo_sel,
  output logic        hi_write,
  output logic        lo_write,
  output logic        done,
  output logic        div_zero,
  output logic        timeout_err,
  output logic        busy
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ZERO,
    S_LAUNCH,
    S_WAIT,
    S_WRITE,
    S_TOUT
  } state_t;

  state_t        state;
  logic          op_q;
  logic [CW-1:0] cnt;
  logic          sel_done;

  // Only the unit that was launched may end the wait.
  assign sel_done = op_q ? div_done : mult_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      op_q        <= 1'b0;
      cnt         <= '0;
      op_ready    <= 1'b1;
      busy        <= 1'b0;
      mult_start  <= 1'b0;
      div_start   <= 1'b0;
      hilo_sel    <= 1'b0;
      hi_write    <= 1'b0;
      lo_write    <= 1'b0;
      done        <= 1'b0;
      div_zero    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      mult_start  <= 1'b0;
      div_start   <= 1'b0;
      hi_write    <= 1'b0;
      lo_write    <= 1'b0;
      done        <= 1'b0;
      div_zero    <= 1'b0;
      timeout_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (op_valid) begin
            op_ready <= 1'b0;
            busy     <= 1'b1;
            if (op_sel && (rt_val == 32'd0)) begin
              state    <= S_ZERO;
              div_zero <= 1'b1;
            end else begin
              state      <= S_LAUNCH;
              op_q       <= op_sel;
              hilo_sel   <= op_sel;
              mult_start <= ~op_sel;
              div_start  <= op_sel;
            end
          end
        end

        S_LAUNCH: begin
          cnt   <= '0;
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (sel_done) begin
            state    <= S_WRITE;
            hi_write <= 1'b1;
            lo_write <= 1'b1;
            done     <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state       <= S_TOUT;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // ZERO, WRITE and TOUT each last one cycle and return to IDLE.
        default: begin
          state    <= S_IDLE;
          op_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_sequencer.sv
// tb/tb_hilo_sequencer.sv - self-checking bench for hilo_sequencer against an event-schedule model
module tb_hilo_sequencer;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_sel;
  logic [31:0] rt_val;
  logic        op_ready;
  logic        mult_start;
  logic        mult_done;
  logic        div_start;
  logic        div_done;
  logic        hilo_sel;
  logic        hi_write;
  logic        lo_write;
  logic        done;
  logic        div_zero;
  logic        timeout_err;
  logic        busy;

  int   total = 0;
  int   bad   = 0;
  logic exp_hilo;
  logic [9:0] obs_v;

  hilo_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .op_valid    (op_valid),
    .op_sel      (op_sel),
    .rt_val      (rt_val),
    .op_ready    (op_ready),
    .mult_start  (mult_start),
    .mult_done   (mult_done),
    .div_start   (div_start),
    .div_done    (div_done),
    .hilo_sel    (hilo_sel),
    .hi_write    (hi_write),
    .lo_write    (lo_write),
    .done        (done),
    .div_zero    (div_zero),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  assign obs_v = {op_ready, busy, mult_start, div_start, hilo_sel,
                  hi_write, lo_write, done, div_zero, timeout_err};

  function automatic logic [9:0] expv(input bit rdy, input bit ms, input bit ds, input logic hs,
                                      input bit wr, input bit dz, input bit to);
    return {rdy, !rdy, ms, ds, hs, wr, wr, wr, dz, to};
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b (ready,busy,ms,ds,hsel,hiw,low,done,dz,to)", tag, obs, exp);
    end
  endtask

  // Event schedule for a request presented in relative cycle 0:
  // start/div_zero at 1, WAIT from 2, WRITE one cycle after the first WAIT cycle
  // that sees the selected done, or timeout at 2+TIMEOUT; ready again after that.
  task automatic run_op(input string name, input bit sel, input logic [31:0] rt,
                        input int done_at, input bit noise);
    bit zero;
    int wr, to, fin, m;
    bit sd, od;
    zero = sel && (rt == 32'd0);
    wr = -1;
    to = -1;
    if (zero) begin
      fin = 2;
    end else begin
      m = (done_at < 2) ? 2 : done_at;
      if (done_at >= 0 && m <= TIMEOUT + 1) begin
        wr  = m + 1;
        fin = m + 2;
      end else begin
        to  = TIMEOUT + 2;
        fin = TIMEOUT + 3;
      end
    end
    for (int c = 0; c < fin; c++) begin
      sd = !zero && done_at >= 0 && c >= done_at && (wr < 0 || c < wr);
      od = noise && c >= 1 && ($urandom % 2 == 1);
      if (c == 0) begin
        op_valid = 1'b1;
        op_sel   = sel;
        rt_val   = rt;
      end else if (noise) begin
        op_valid = 1'b1;
        op_sel   = 1'($urandom % 2);
        rt_val   = ($urandom % 2 == 1) ? 32'd0 : $urandom;
      end else begin
        op_valid = 1'b0;
      end
      mult_done = sel ? od : sd;
      div_done  = sel ? sd : od;
      if (c == 1 && !zero) exp_hilo = sel;
      @(negedge clk);
      chk($sformatf("%s c%0d", name, c), obs_v,
          expv(c == 0, !zero && !sel && c == 1, !zero && sel && c == 1, exp_hilo,
               c == wr, zero && c == 1, c == to));
      @(posedge clk);
      #1;
    end
    op_valid  = 1'b0;
    mult_done = 1'b0;
    div_done  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      op_valid  = 1'b0;
      op_sel    = 1'($urandom % 2);
      mult_done = 1'($urandom % 2);
      div_done  = 1'($urandom % 2);
      @(negedge clk);
      chk($sformatf("idle c%0d", c), obs_v, expv(1, 0, 0, exp_hilo, 0, 0, 0));
      @(posedge clk);
      #1;
    end
    mult_done = 1'b0;
    div_done  = 1'b0;
  endtask

  // Divide in flight, reset during WAIT at cycle 10, late div_done from cycle 12.
  task automatic reset_mid_op();
    for (int c = 0; c < 16; c++) begin
      op_valid = (c == 0);
      op_sel   = 1'b1;
      rt_val   = 32'd3;
      reset    = (c == 10);
      div_done = (c >= 12);
      if (c == 1) exp_hilo = 1'b1;
      if (c == 11) exp_hilo = 1'b0;
      @(negedge clk);
      chk($sformatf("rst c%0d", c), obs_v,
          expv(c == 0 || c >= 11, 0, c == 1, exp_hilo, 0, 0, 0));
      @(posedge clk);
      #1;
    end
    reset    = 1'b0;
    div_done = 1'b0;
  endtask

  initial begin
    int sel, dsel, dat;
    logic [31:0] rt;
    reset     = 1'b1;
    op_valid  = 1'b0;
    op_sel    = 1'b0;
    rt_val    = 32'd0;
    mult_done = 1'b0;
    div_done  = 1'b0;
    exp_hilo  = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset", obs_v, expv(1, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    @(posedge clk);
    #1;
    idle(2);

    run_op("mult", 1'b0, 32'd0, 5, 1'b0);
    idle(1);
    run_op("divzero", 1'b1, 32'd0, 3, 1'b0);
    run_op("div", 1'b1, 32'd3, 33, 1'b0);
    run_op("div_msb", 1'b1, 32'h8000_0000, 2, 1'b0);
    run_op("mult_first", 1'b0, 32'd0, 0, 1'b0);
    run_op("tout", 1'b0, 32'd0, -1, 1'b0);
    run_op("tout_edge", 1'b0, 32'd0, TIMEOUT + 1, 1'b0);
    run_op("tout_late", 1'b1, 32'd7, TIMEOUT + 2, 1'b0);
    run_op("xtalk", 1'b0, 32'd0, 5, 1'b1);
    run_op("held", 1'b1, 32'd3, 4, 1'b0);
    idle(1);
    reset_mid_op();
    idle(2);

    for (int i = 0; i < 24; i++) begin
      sel  = $urandom % 2;
      rt   = ($urandom % 4 == 0) ? 32'd0 : $urandom;
      dsel = $urandom % 8;
      if (dsel == 0) dat = -1;
      else if (dsel == 1) dat = TIMEOUT + int'($urandom % 3);
      else dat = int'($urandom_range(0, 20));
      run_op($sformatf("rnd%0d", i), 1'(sel), rt, dat, 1'($urandom % 2));
      if ($urandom % 2 == 1) idle(1 + int'($urandom % 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
